// File: rtl/or1200_operand_pkg.sv
// Shared select-code constants and width helpers for the OR1200 operand stage.
package or1200_operand_pkg;

  // Per-lane select codes: register file, immediate, then forwarding stages.
  localparam int SEL_RF       = 0;
  localparam int SEL_IMM      = 1;
  localparam int SEL_FWD_BASE = 2;

  // Select code that picks forwarding stage k (0 = EX, 1 = WB, ...).
  function automatic int fwd_sel(input int k);
    return SEL_FWD_BASE + k;
  endfunction

  // Width of one lane's select field for a given number of forwarding stages.
  function automatic int sel_width(input int nfwd);
    return $clog2(nfwd + 2);
  endfunction

endpackage

// File: rtl/or1200_operand_lane.sv
// One operand lane: source mux, forwarding-not-ready detection, operand
// register and the saved flag that keeps a captured value across ID freeze.
module or1200_operand_lane
  import or1200_operand_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NFWD  = 2,
  parameter int SW    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_freeze,
  input  logic                  ex_freeze,
  input  logic                  cap,
  input  logic [SW-1:0]         sel,
  input  logic [WIDTH-1:0]      rf,
  input  logic [WIDTH-1:0]      simm,
  input  logic [NFWD*WIDTH-1:0] fwd_data,
  input  logic [NFWD-1:0]       fwd_valid,
  output logic [WIDTH-1:0]      muxed,
  output logic [WIDTH-1:0]      operand,
  output logic                  saved,
  output logic                  need
);

  // Source decode; reserved codes fall through to the register-file value.
  // A saved lane never asks for a stall, whatever its select points at.
  always_comb begin
    muxed = rf;
    need  = 1'b0;
    if (int'(sel) == SEL_IMM) begin
      muxed = simm;
    end
    for (int k = 0; k < NFWD; k++) begin
      if (int'(sel) == fwd_sel(k)) begin
        muxed = fwd_data[k*WIDTH +: WIDTH];
        need  = !fwd_valid[k] && !saved;
      end
    end
  end

  // Capture when the whole stage may capture; remember the capture if ID is
  // frozen so the next unfrozen edge only releases the flag, never recaptures.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      operand <= '0;
      saved   <= 1'b0;
    end else if (cap && !saved) begin
      operand <= muxed;
      saved   <= id_freeze;
    end else if (!ex_freeze && !id_freeze && saved) begin
      saved   <= 1'b0;
    end
  end

endmodule

// File: rtl/or1200_operand_stage.sv
// Operand select and ID->EX operand latch for NOPS lanes with NFWD
// forwarding stages; raises stall_req while a selected forward is not final.
module or1200_operand_stage
  import or1200_operand_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NOPS  = 2,
  parameter int NFWD  = 2,
  localparam int SW   = sel_width(NFWD)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_freeze,
  input  logic                  ex_freeze,
  input  logic [NOPS*WIDTH-1:0] rf_data,
  input  logic [WIDTH-1:0]      simm,
  input  logic [NFWD*WIDTH-1:0] fwd_data,
  input  logic [NFWD-1:0]       fwd_valid,
  input  logic [NOPS*SW-1:0]    sel,
  output logic [NOPS*WIDTH-1:0] muxed,
  output logic [NOPS*WIDTH-1:0] operand,
  output logic [NOPS-1:0]       saved,
  output logic                  stall_req
);

  logic [NOPS-1:0] need;
  logic            cap;

  // Any lane waiting on a forward blocks every lane; lanes capture as a set.
  assign stall_req = |need;
  assign cap       = !ex_freeze && !stall_req;

  genvar gi;
  generate
    for (gi = 0; gi < NOPS; gi++) begin : g_lane
      or1200_operand_lane #(
        .WIDTH(WIDTH),
        .NFWD (NFWD),
        .SW   (SW)
      ) u_lane (
        .clk      (clk),
        .rst      (rst),
        .id_freeze(id_freeze),
        .ex_freeze(ex_freeze),
        .cap      (cap),
        .sel      (sel[gi*SW +: SW]),
        .rf       (rf_data[gi*WIDTH +: WIDTH]),
        .simm     (simm),
        .fwd_data (fwd_data),
        .fwd_valid(fwd_valid),
        .muxed    (muxed[gi*WIDTH +: WIDTH]),
        .operand  (operand[gi*WIDTH +: WIDTH]),
        .saved    (saved[gi]),
        .need     (need[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_or1200_operand_stage.sv
// Self-checking bench: directed scenarios plus random stimulus, compared each
// cycle against a behavioural model of the operand stage.
module tb_or1200_operand_stage;
  import or1200_operand_pkg::*;

  localparam int W    = 32;
  localparam int NOPS = 2;
  localparam int NFWD = 2;
  localparam int SW   = sel_width(NFWD);

  logic                 clk;
  logic                 rst;
  logic                 id_freeze;
  logic                 ex_freeze;
  logic [NOPS*W-1:0]    rf_data;
  logic [W-1:0]         simm;
  logic [NFWD*W-1:0]    fwd_data;
  logic [NFWD-1:0]      fwd_valid;
  logic [NOPS*SW-1:0]   sel;
  logic [NOPS*W-1:0]    muxed;
  logic [NOPS*W-1:0]    operand;
  logic [NOPS-1:0]      saved;
  logic                 stall_req;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [W-1:0] m_op[NOPS];
  bit           m_sv[NOPS];

  or1200_operand_stage #(.WIDTH(W), .NOPS(NOPS), .NFWD(NFWD)) dut (
    .clk      (clk),
    .rst      (rst),
    .id_freeze(id_freeze),
    .ex_freeze(ex_freeze),
    .rf_data  (rf_data),
    .simm     (simm),
    .fwd_data (fwd_data),
    .fwd_valid(fwd_valid),
    .sel      (sel),
    .muxed    (muxed),
    .operand  (operand),
    .saved    (saved),
    .stall_req(stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Value a lane should present, straight from the select-code table.
  function automatic logic [W-1:0] ref_mux(input int i);
    int code;
    code = int'(sel[i*SW +: SW]);
    if (code == 1) return simm;
    if (code >= 2 && code - 2 < NFWD) return fwd_data[(code-2)*W +: W];
    return rf_data[i*W +: W];
  endfunction

  function automatic bit ref_stall();
    int code;
    bit s;
    s = 1'b0;
    for (int i = 0; i < NOPS; i++) begin
      code = int'(sel[i*SW +: SW]);
      if (code >= 2 && code - 2 < NFWD && !fwd_valid[code-2] && !m_sv[i]) s = 1'b1;
    end
    return s;
  endfunction

  task automatic set_sel(input int i, input int code);
    sel[i*SW +: SW] = SW'(code);
  endtask

  // Compare all outputs with the model, then advance one clock edge.
  // Called just after a falling edge; returns on the next falling edge.
  task automatic cycle();
    logic [W-1:0] nx[NOPS];
    bit st;
    bit cap;
    #1;
    st = ref_stall();
    check("stall_req", W'(stall_req), W'(st));
    for (int i = 0; i < NOPS; i++) begin
      nx[i] = ref_mux(i);
      check($sformatf("muxed%0d", i), muxed[i*W +: W], nx[i]);
      check($sformatf("operand%0d", i), operand[i*W +: W], m_op[i]);
      check($sformatf("saved%0d", i), W'(saved[i]), W'(m_sv[i]));
    end
    cap = !ex_freeze && !st;
    $display("cyc %0d sel=%h idf=%0b exf=%0b fv=%b stall=%0b op0=%h op1=%h sv=%b",
             cyc, sel, id_freeze, ex_freeze, fwd_valid, stall_req,
             operand[0 +: W], operand[W +: W], saved);
    @(posedge clk);
    for (int i = 0; i < NOPS; i++) begin
      if (cap && !m_sv[i]) begin
        m_op[i] = nx[i];
        m_sv[i] = id_freeze;
      end else if (!ex_freeze && !id_freeze && m_sv[i]) begin
        m_sv[i] = 1'b0;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    logic [W-1:0] snap0;
    logic [W-1:0] snap1;
    logic [NOPS-1:0] snap_sv;

    rst = 1'b1; id_freeze = 1'b0; ex_freeze = 1'b0;
    rf_data = '0; simm = '0; fwd_data = '0; fwd_valid = '0; sel = '0;
    for (int i = 0; i < NOPS; i++) begin m_op[i] = '0; m_sv[i] = 1'b0; end
    repeat (2) @(negedge clk);
    #1;
    check("reset_operand", operand[W-1:0], 32'h0);
    check("reset_saved", W'(saved), 32'h0);
    rst = 1'b0;

    // Capture a value, then reset asynchronously mid-cycle.
    rf_data[0 +: W] = 32'hDEAD_BEEF;
    cycle();
    check("op0_deadbeef", operand[0 +: W], 32'hDEAD_BEEF);
    #2 rst = 1'b1;
    #1;
    check("async_rst_op0", operand[0 +: W], 32'h0);
    check("async_rst_saved", W'(saved), 32'h0);
    for (int i = 0; i < NOPS; i++) begin m_op[i] = '0; m_sv[i] = 1'b0; end
    @(negedge clk);
    rst = 1'b0;
    rf_data[0 +: W] = 32'h11;
    cycle();
    check("op0_after_rst", operand[0 +: W], 32'h11);

    // Source decode.
    set_sel(1, 1); simm = 32'hFFFF_FFF0;
    #1 check("muxed1_imm", muxed[W +: W], 32'hFFFF_FFF0);
    cycle();
    set_sel(0, 2); fwd_data[0 +: W] = 32'h1234; fwd_valid = 2'b11;
    cycle();
    check("op0_fwd_ex", operand[0 +: W], 32'h1234);
    set_sel(0, 3); fwd_data[W +: W] = 32'h5678;
    cycle();
    check("op0_fwd_wb", operand[0 +: W], 32'h5678);

    // Forwarding stall, then release.
    fwd_valid = 2'b01; fwd_data[W +: W] = 32'hABCD;
    repeat (3) begin
      #1 check("stall_wait", W'(stall_req), 32'h1);
      cycle();
      check("op0_hold_stall", operand[0 +: W], 32'h5678);
    end
    fwd_valid = 2'b11;
    #1 check("stall_release", W'(stall_req), 32'h0);
    cycle();
    check("op0_after_stall", operand[0 +: W], 32'hABCD);

    // Freeze save.
    set_sel(0, 0); rf_data[0 +: W] = 32'h55; id_freeze = 1'b1;
    cycle();
    check("save_op0", operand[0 +: W], 32'h55);
    check("save_flag", W'(saved[0]), 32'h1);
    rf_data[0 +: W] = 32'h66;
    repeat (2) begin
      cycle();
      check("saved_hold_op0", operand[0 +: W], 32'h55);
    end
    id_freeze = 1'b0;
    cycle();
    check("clear_flag", W'(saved[0]), 32'h0);
    check("clear_op0_hold", operand[0 +: W], 32'h55);
    cycle();
    check("recapture_op0", operand[0 +: W], 32'h66);

    // EX freeze dominates everything.
    ex_freeze = 1'b1; set_sel(0, 3); fwd_valid = 2'b01;
    snap0 = operand[0 +: W]; snap1 = operand[W +: W]; snap_sv = saved;
    for (int j = 0; j < 4; j++) begin
      id_freeze = j[0];
      #1 check("exf_stall", W'(stall_req), 32'h1);
      cycle();
      check("exf_op0", operand[0 +: W], snap0);
      check("exf_op1", operand[W +: W], snap1);
      check("exf_saved", W'(saved), W'(snap_sv));
    end
    ex_freeze = 1'b0; id_freeze = 1'b0; fwd_valid = 2'b11;
    cycle();

    // Saved lanes mask forwarding stalls.
    set_sel(0, 0); set_sel(1, 1); id_freeze = 1'b1;
    cycle();
    set_sel(0, 2); set_sel(1, 3); fwd_valid = 2'b00;
    #1 check("saved_masks_stall", W'(stall_req), 32'h0);
    cycle();
    check("saved_kept", W'(saved), 32'h3);
    id_freeze = 1'b0;
    cycle();
    set_sel(0, 0);
    snap0 = operand[0 +: W]; snap1 = operand[W +: W];
    #1 check("lane1_stall", W'(stall_req), 32'h1);
    cycle();
    check("no_partial_op0", operand[0 +: W], snap0);
    check("no_partial_op1", operand[W +: W], snap1);

    // Random traffic against the model.
    repeat (400) begin
      for (int i = 0; i < NOPS; i++) set_sel(i, int'($urandom_range(0, (1 << SW) - 1)));
      rf_data   = {$urandom, $urandom};
      simm      = $urandom;
      fwd_data  = {$urandom, $urandom};
      for (int k = 0; k < NFWD; k++) fwd_valid[k] = ($urandom_range(0, 3) != 0);
      id_freeze = ($urandom_range(0, 3) == 0);
      ex_freeze = ($urandom_range(0, 4) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
